// File: rtl/cdc_share_arb_pkg.sv
// Shared encodings and helpers for the cdc_share_arb write-domain FSM and select width.
package cdc_share_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Ceiling log2, never below 1 so a select bus always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_share_arb.sv
// N-requester arbiter feeding a four-phase req/ack crossing from wclk to rclk.
// Define CDC_SHARE_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module cdc_share_arb
    import cdc_share_arb_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int W_DATA      = 32,
    parameter  int SYNC_STAGES = 2,
    localparam int SEL_W       = clog2(N_REQ)
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*W_DATA-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    wbusy,
    output logic                    out_valid,
    output logic [W_DATA-1:0]       out_data,
    output logic [SEL_W-1:0]        out_sel
);

    // After a write-side reset the ack synchroniser reads 0 until it refills,
    // so grants wait until the ack seen is the real read-side state.
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = clog2(ARM_MAX + 1);

    logic [1:0]        state;
    logic              wreq;
    logic              ack_s;
    logic              rack;
    logic              wreq_s;
    logic [W_DATA-1:0] xreg_data;
    logic [SEL_W-1:0]  xreg_sel;
    logic [SEL_W-1:0]  win;
    logic [W_DATA-1:0] win_data;
    logic              grant;
    logic [ARM_W-1:0]  arm_cnt;
    logic              armed;

    assign armed = (arm_cnt == ARM_W'(ARM_MAX));

`ifdef CDC_SHARE_ARB_RR_EN
    logic [SEL_W-1:0] last_ptr;
    logic [SEL_W-1:0] win_hi;
    logic [SEL_W-1:0] win_lo;
    logic             hi_found;

    // Lowest valid index above the last grant wins; otherwise wrap to the lowest valid index.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        hi_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (SEL_W'(i) > last_ptr) begin
                    hi_found = 1'b1;
                    win_hi   = SEL_W'(i);
                end else begin
                    win_lo = SEL_W'(i);
                end
            end
        end
        win = hi_found ? win_hi : win_lo;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            last_ptr <= SEL_W'(N_REQ - 1);
        end else if (grant) begin
            last_ptr <= win;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) win = SEL_W'(i);
        end
    end
`endif

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == SEL_W'(i)) win_data = req_data[i*W_DATA +: W_DATA];
        end
    end

    assign grant     = armed && (state == ST_IDLE) && (|req_valid) && !ack_s;
    assign req_ready = grant ? (N_REQ'(1) << win) : '0;
    assign wbusy     = (state != ST_IDLE);

    // Write domain: wreq follows SEND one cycle late so the crossing register
    // has settled for a full cycle before the request edge leaves.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= ST_IDLE;
            wreq      <= 1'b0;
            xreg_data <= '0;
            xreg_sel  <= '0;
            arm_cnt   <= '0;
        end else begin
            if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
            wreq <= (state == ST_SEND);
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        xreg_data <= win_data;
                        xreg_sel  <= win;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND:    if (ack_s)  state <= ST_RELEASE;
                ST_RELEASE: if (!ack_s) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wreq (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wreq),
        .q     (wreq_s)
    );

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rack),
        .q     (ack_s)
    );

    // Read domain: capture on the synchronised request edge, ack until it drops.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rack      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (wreq_s && !rack) begin
                out_data  <= xreg_data;
                out_sel   <= xreg_sel;
                out_valid <= 1'b1;
                rack      <= 1'b1;
            end else if (!wreq_s && rack) begin
                rack <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdc_share_arb.sv
// Directed bench for cdc_share_arb: reset, single word, contention, starvation, clock ratios, resets.
module tb_cdc_share_arb;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic            wclk, rclk, wrst_n, rrst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            wbusy, out_valid;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_sel;

    int whalf = 5;
    int rhalf = 7;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] txq [NR][$];
    logic [31:0] pq  [NR][$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          rdy_cnt [NR];
    int          dbl_cnt;
    logic        prev_v;
    logic [NR-1:0] acc;

    cdc_share_arb #(.N_REQ(NR), .W_DATA(W), .SYNC_STAGES(2)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wbusy     (wbusy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial begin
        wclk = 1'b0;
        forever #(whalf) wclk = ~wclk;
    end

    initial begin
        rclk = 1'b0;
        forever #(rhalf) rclk = ~rclk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int s, input logic [31:0] d);
        return {32'(s), d};
    endfunction

    function automatic logic [63:0] got_at(input int k);
        if (k < got_q.size()) return got_q[k];
        return '1;
    endfunction

    // Requester model: each queue front is offered until accepted.
    initial begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
        forever begin
            @(negedge wclk);
            acc = req_valid & req_ready;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    exp_q.push_back(mk(i, req_data[i*W +: W]));
                    rdy_cnt[i]++;
                end
            end
            @(posedge wclk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && txq[i].size() > 0) void'(txq[i].pop_front());
                req_valid[i] = (txq[i].size() > 0);
                req_data[i*W +: W] = (txq[i].size() > 0) ? txq[i][0] : '0;
            end
        end
    end

    initial begin
        prev_v  = 1'b0;
        dbl_cnt = 0;
        forever begin
            @(negedge rclk);
            if (out_valid) begin
                got_q.push_back(mk(int'(out_sel), out_data));
                if (prev_v) dbl_cnt++;
            end
            prev_v = out_valid;
        end
    end

    task automatic wait_got(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge wclk);
            c++;
        end
        if (got_q.size() < n) check_eq(tag, 64'(got_q.size()), 64'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c;
        bit done;
        c = 0;
        done = 0;
        while (!done && c < budget) begin
            @(negedge wclk);
            c++;
            done = !wbusy && got_q.size() >= exp_q.size();
            for (int i = 0; i < NR; i++) if (txq[i].size() > 0) done = 0;
        end
        if (!done) check_eq(tag, 64'(wbusy), 64'(0));
        repeat (30) @(posedge wclk);
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        dbl_cnt = 0;
        for (int i = 0; i < NR; i++) begin
            rdy_cnt[i] = 0;
            pq[i].delete();
        end
    endtask

    initial begin
        int c;
        int mism;
        int ok;
        int s;
        logic [31:0] d;
        logic [63:0] e;

        // Reset state with a requester already offering a word.
        wrst_n = 1'b0;
        rrst_n = 1'b0;
        txq[1].push_back(32'h1111_1111);
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        check_eq("rst_wbusy", 64'(wbusy), 64'(0));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_data", 64'(out_data), 64'(0));
        check_eq("rst_out_sel", 64'(out_sel), 64'(0));
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        rrst_n = 1'b1;
        wait_got("p0_timeout", 1, 300);
        check_eq("p0_word", got_at(0), mk(1, 32'h1111_1111));
        wait_idle("p0_idle", 500);
        clear_sb();

        // Single word from requester 2.
        txq[2].push_back(32'hDEAD_BEEF);
        wait_got("p1_timeout", 1, 300);
        wait_idle("p1_idle", 500);
        check_eq("p1_word", got_at(0), mk(2, 32'hDEAD_BEEF));
        check_eq("p1_count", 64'(got_q.size()), 64'(1));
        check_eq("p1_ready2", 64'(rdy_cnt[2]), 64'(1));
        check_eq("p1_ready_all", 64'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3]), 64'(0));
        clear_sb();

        // Contention: all four offer at once.
        for (int i = 0; i < NR; i++) txq[i].push_back(32'(32'h10 + i));
        wait_got("p2_timeout", 4, 1000);
        wait_idle("p2_idle", 1000);
        for (int k = 0; k < 4; k++) check_eq("p2_word", got_at(k), mk(k, 32'(32'h10 + k)));
        check_eq("p2_count", 64'(got_q.size()), 64'(4));
        clear_sb();

        // Requesters 0 and 3 permanently valid.
        for (int j = 0; j < 12; j++) begin
            txq[0].push_back(32'(32'hA000 + j));
            txq[3].push_back(32'(32'hA300 + j));
        end
        wait_got("p3_timeout", 8, 2000);
        for (int k = 0; k < 8; k++) begin
`ifdef CDC_SHARE_ARB_RR_EN
            e = (k % 2 == 0) ? mk(0, 32'(32'hA000 + k / 2)) : mk(3, 32'(32'hA300 + k / 2));
`else
            e = mk(0, 32'(32'hA000 + k));
`endif
            check_eq("p3_seq", got_at(k), e);
        end
        @(posedge wclk);
        #3;
        txq[0].delete();
        txq[3].delete();
        wait_idle("p3_idle", 1000);
        clear_sb();

        // Clock ratios 1:7 and 7:1 with random traffic.
        for (int r = 0; r < 2; r++) begin
            whalf = (r == 0) ? 5 : 35;
            rhalf = (r == 0) ? 35 : 5;
            repeat (10) @(posedge wclk);
            for (int j = 0; j < 200; j++) begin
                s = $urandom_range(0, NR - 1);
                d = $urandom;
                txq[s].push_back(d);
                pq[s].push_back(d);
            end
            wait_got("p4_timeout", 200, 30000);
            wait_idle("p4_idle", 2000);
            check_eq("p4_delivered", 64'(got_q.size()), 64'(200));
            check_eq("p4_accepted", 64'(exp_q.size()), 64'(200));
            mism = 0;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (got_at(k) !== exp_q[k]) mism++;
                s = int'(exp_q[k][63:32]);
                if (s < NR && pq[s].size() > 0) begin
                    if (pq[s].pop_front() !== exp_q[k][31:0]) mism++;
                end else begin
                    mism++;
                end
            end
            check_eq("p4_order", 64'(mism), 64'(0));
            check_eq("p4_pulse", 64'(dbl_cnt), 64'(0));
            clear_sb();
        end
        whalf = 5;
        rhalf = 7;
        repeat (10) @(posedge wclk);

        // Write-side reset right after acceptance drops the word.
        txq[0].push_back(32'hCAFE_0001);
        c = 0;
        @(negedge wclk);
        while (!(req_valid[0] && req_ready[0]) && c < 200) begin
            @(negedge wclk);
            c++;
        end
        check_eq("p5a_accept", 64'(req_valid[0] & req_ready[0]), 64'(1));
        @(posedge wclk);
        #1;
        wrst_n = 1'b0;
        #2;
        check_eq("p5a_rst_wbusy", 64'(wbusy), 64'(0));
        repeat (3) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (60) @(posedge wclk);
        check_eq("p5a_dropped", 64'(got_q.size()), 64'(0));
        txq[3].push_back(32'hCAFE_0002);
        wait_got("p5a_timeout", 1, 300);
        wait_idle("p5a_idle", 500);
        check_eq("p5a_next", got_at(0), mk(3, 32'hCAFE_0002));
        check_eq("p5a_count", 64'(got_q.size()), 64'(1));
        clear_sb();

        // Read-side reset just after delivery while the request is still high.
        txq[1].push_back(32'hCAFE_0003);
        wait_got("p5b_timeout", 1, 300);
        @(posedge rclk);
        #1;
        rrst_n = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
        c = 0;
        while ((wbusy || txq[1].size() > 0) && c < 1000) begin
            @(negedge wclk);
            c++;
        end
        repeat (40) @(posedge wclk);
        ok = (got_q.size() >= 1 && got_q.size() <= 2) ? 1 : 0;
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== mk(1, 32'hCAFE_0003)) ok = 0;
        check_eq("p5b_dup_bound", 64'(ok), 64'(1));
        clear_sb();
        txq[2].push_back(32'hCAFE_0004);
        wait_got("p5b_timeout2", 1, 300);
        wait_idle("p5b_idle", 500);
        check_eq("p5b_resume", got_at(0), mk(2, 32'hCAFE_0004));
        check_eq("p5b_count", 64'(got_q.size()), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(20_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
